spi_master_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one spi_master core among NUM_REQ requesters.

---
 rtl/spi_master_arbiter_if.sv | 36 +++
 rtl/spi_master_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter_if.sv
// Requester, response and spi_master-facing signals of spi_master_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [3*NUM_REQ-1:0] i_req_slave;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [NUM_REQ-1:0]   o_rsp_valid;
  logic [7:0]           o_rsp_data;
  logic                 o_timeout;
  logic                 o_busy;
  logic [2:0]           o_grant_id;
  logic                 o_spi_tx_valid;
  logic [2:0]           o_spi_slave_select;
  logic [7:0]           o_spi_tx_data;
  logic                 i_spi_tx_ready;
  logic                 i_spi_rx_valid;
  logic [7:0]           i_spi_rx_data;

  modport master (
    input  i_req_valid, i_req_last, i_req_slave, i_req_data,
    input  i_spi_tx_ready, i_spi_rx_valid, i_spi_rx_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_timeout, o_busy, o_grant_id,
    output o_spi_tx_valid, o_spi_slave_select, o_spi_tx_data
  );

  modport slave (
    output i_req_valid, i_req_last, i_req_slave, i_req_data,
    output i_spi_tx_ready, i_spi_rx_valid, i_spi_rx_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_timeout, o_busy, o_grant_id,
    input  o_spi_tx_valid, o_spi_slave_select, o_spi_tx_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin sequencer sharing one spi_master among NUM_REQ requesters, with an RX watchdog.
// Optional burst lock on the current owner is enabled by defining SPI_ARB_BURST_LOCK_EN.
module spi_master_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int RX_TIMEOUT_CLKS = 256
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  spi_master_arbiter_if.master bus
);
  localparam int WDW = (RX_TIMEOUT_CLKS > 1) ? $clog2(RX_TIMEOUT_CLKS) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(RX_TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         slave_q, slave_d;
  logic [7:0]         data_q, data_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;

  logic               found;
  logic               accept;
  logic               timeout_hit;
  logic [2:0]         win;
  logic [2:0]         next_ptr;
  logic [2:0]         win_slave;
  logic [7:0]         win_data;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] ready_vec;

  logic [2:0] slave_arr [NUM_REQ];
  logic [7:0] data_arr  [NUM_REQ];

`ifdef SPI_ARB_BURST_LOCK_EN
  logic lock_q, lock_d;
  logic owner_valid;
  logic win_last;
`else
  logic unused_last;
  assign unused_last = ^bus.i_req_last;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign slave_arr[gi] = bus.i_req_slave[3*gi +: 3];
    assign data_arr[gi]  = bus.i_req_data[8*gi +: 8];
  end

  // Rotating priority: indices at or above the pointer first, then the wrapped-around ones.
  always_comb begin : arb
    found        = 1'b0;
    win          = 3'd0;
    owner_onehot = '0;
`ifdef SPI_ARB_BURST_LOCK_EN
    owner_valid  = 1'b0;
`endif
    for (int j = 0; j < NUM_REQ; j++) begin
      owner_onehot[j] = (grant_q == 3'(j));
`ifdef SPI_ARB_BURST_LOCK_EN
      if (owner_onehot[j] && bus.i_req_valid[j]) owner_valid = 1'b1;
`endif
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && (3'(j) >= ptr_q) && bus.i_req_valid[j]) begin
        found = 1'b1;
        win   = 3'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && (3'(j) < ptr_q) && bus.i_req_valid[j]) begin
        found = 1'b1;
        win   = 3'(j);
      end
    end
`ifdef SPI_ARB_BURST_LOCK_EN
    if (lock_q && owner_valid) begin
      found = 1'b1;
      win   = grant_q;
    end
`endif
  end

  always_comb begin : sel
    win_slave = 3'd0;
    win_data  = 8'd0;
`ifdef SPI_ARB_BURST_LOCK_EN
    win_last  = 1'b0;
`endif
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == 3'(j)) begin
        win_slave = slave_arr[j];
        win_data  = data_arr[j];
`ifdef SPI_ARB_BURST_LOCK_EN
        win_last  = bus.i_req_last[j];
`endif
      end
    end
  end

  assign accept      = (state_q == IDLE) && bus.i_spi_tx_ready && found;
  assign next_ptr    = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
  assign timeout_hit = (state_q == WAIT_RX) && !bus.i_spi_rx_valid && (wdog_q == WD_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      grant_q     <= 3'd0;
      slave_q     <= 3'd0;
      data_q      <= 8'd0;
      wdog_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'd0;
`ifdef SPI_ARB_BURST_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      slave_q     <= slave_d;
      data_q      <= data_d;
      wdog_q      <= wdog_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SPI_ARB_BURST_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    slave_d     = slave_q;
    data_d      = data_q;
    wdog_d      = wdog_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef SPI_ARB_BURST_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef SPI_ARB_BURST_LOCK_EN
        // An idle owner gives up the lock; the same cycle arbitrates normally.
        if (bus.i_spi_tx_ready && lock_q && !owner_valid) lock_d = 1'b0;
`endif
        if (accept) begin
          state_d = ISSUE;
          grant_d = win;
          slave_d = win_slave;
          data_d  = win_data;
          ptr_d   = next_ptr;
`ifdef SPI_ARB_BURST_LOCK_EN
          if (!win_last) begin
            lock_d = 1'b1;
            ptr_d  = ptr_q;
          end else begin
            lock_d = 1'b0;
          end
`endif
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT_RX;
      end
      WAIT_RX: begin
        if (bus.i_spi_rx_valid) begin
          rsp_valid_d = owner_onehot;
          rsp_data_d  = bus.i_spi_rx_data;
          state_d     = IDLE;
        end else if (wdog_q == WD_MAX) begin
          state_d = IDLE;
`ifdef SPI_ARB_BURST_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    ready_vec = '0;
    for (int j = 0; j < NUM_REQ; j++) ready_vec[j] = accept && (win == 3'(j));
    bus.o_req_ready        = ready_vec;
    bus.o_rsp_valid        = rsp_valid_q;
    bus.o_rsp_data         = rsp_data_q;
    bus.o_timeout          = timeout_hit;
    bus.o_busy             = (state_q != IDLE);
    bus.o_grant_id         = grant_q;
    bus.o_spi_tx_valid     = (state_q == ISSUE);
    bus.o_spi_slave_select = slave_q;
    bus.o_spi_tx_data      = data_q;
  end
endmodule
